// File: rtl/riscv_muldiv_if.sv
// riscv_muldiv_if: request/response bundle for the execute-stage mul/div unit.
// master drives the request, slave returns busy/done/result.
interface riscv_muldiv_if #(
  parameter int W = 32
);
  logic         start;
  logic         flush;
  logic [2:0]   funct3;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  modport master (
    output start, flush, funct3, op1, op2,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op1, op2,
    output busy, done, result
  );
endinterface

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide, one bit per cycle.
// RISCV_MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module riscv_muldiv #(
  parameter int WORD_LENGTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  riscv_muldiv_if.slave bus
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     f3_q, f3_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   result_q, result_d;

  function automatic logic [W-1:0] mul_sel(
    input logic [1:0]     f,
    input logic [2*W-1:0] p
  );
    return (f == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  logic         sgn_a, sgn_b, sa, sb;
  logic [W-1:0] amag, bmag;
  logic         div_zero, ovf, special;
  logic [W-1:0] spec_val;

  always_comb begin
    sgn_a = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn_b = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    sa    = sgn_a & bus.op1[W-1];
    sb    = sgn_b & bus.op2[W-1];
    amag  = sa ? -bus.op1 : bus.op1;
    bmag  = sb ? -bus.op2 : bus.op2;
    div_zero = bus.funct3[2] && (bus.op2 == '0);
    ovf = (bus.funct3 inside {3'b100, 3'b110})
       && (bus.op1 == {1'b1, {(W-1){1'b0}}})
       && (bus.op2 == '1);
    special = div_zero | ovf;
    if (div_zero)
      spec_val = bus.funct3[1] ? bus.op1 : '1;
    else
      spec_val = bus.funct3[1] ? '0 : bus.op1;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  logic [W:0]     mul_sum, rem_sh, diff;
  logic [2*W-1:0] mul_nx, div_nx, step, prod;
  logic [W-1:0]   quo, rem, fin, done_val;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]}
            + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nx  = {mul_sum, acc_q[W-1:1]};
    rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    diff    = rem_sh - {1'b0, b_q};
    if (diff[W])
      div_nx = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    else
      div_nx = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    step = f3_q[2] ? div_nx : mul_nx;
    prod = negq_q ? -step : step;
    quo  = step[W-1:0];
    rem  = step[2*W-1:W];
    fin  = '0;
    unique case (1'b1)
      !f3_q[2]:
        fin = mul_sel(f3_q[1:0], prod);
      f3_q[2] && !f3_q[1]:
        fin = negq_q ? -quo : quo;
      f3_q[2] && f3_q[1]:
        fin = negr_q ? -rem : rem;
      default: fin = '0;
    endcase
  end

`ifdef RISCV_MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fprod, fsgn;
  always_comb begin
    fprod    = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    fsgn     = negq_q ? -fprod : fprod;
    done_val = f3_q[2] ? res_q : mul_sel(f3_q[1:0], fsgn);
  end
`else
  assign done_val = res_q;
`endif

  assign bus.busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    a_d        = a_q;
    b_d        = b_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    acc_d      = acc_q;
    res_d      = res_q;
    result_d   = result_q;
    bus.done   = 1'b0;
    bus.result = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          f3_d   = bus.funct3;
          a_d    = amag;
          b_d    = bmag;
          negq_d = sa ^ sb;
          negr_d = sa;
          acc_d  = {{W{1'b0}}, bus.funct3[2] ? amag : bmag};
          cnt_d  = CW'(W - 1);
          if (special) begin
            res_d   = spec_val;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
`ifdef RISCV_MULDIV_FAST_MUL_EN
          if (!bus.funct3[2])
            state_d = DONE;
`endif
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          if (cnt_q == '0) begin
            res_d   = fin;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        // A kill in the done cycle suppresses the writeback entirely.
        if (!bus.flush) begin
          bus.done   = 1'b1;
          bus.result = done_val;
          result_d   = done_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed vectors with a queue scoreboard and
// a done-driven monitor checking result and completion cycle.
module tb_riscv_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_muldiv_if #(.W(32)) bus ();

  riscv_muldiv #(.WORD_LENGTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

`ifdef RISCV_MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", bus.result, e.res);
        chk("done cycle", 32'(cyc), 32'(e.cyc));
        chk("busy at done", {31'd0, bus.busy}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int lat, input bit push, output int c0);
    @(negedge clk);
    bus.funct3 = f;
    bus.op1    = a;
    bus.op2    = b;
    bus.start  = 1'b1;
    c0 = cyc + 1;
    if (push) q.push_back('{exp, c0 + lat - 1});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op1   = ~a;
    bus.op2   = ~b;
    bus.funct3 = ~f;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      chk("drain timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp,
                     input int lat);
    int c0;
    issue(f, a, b, exp, lat, 1'b1, c0);
    drain();
  endtask

  initial begin
    int c0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op1    = '0;
    bus.op2    = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    rst_n = 1'b1;

    issue(3'b000, 32'd7, 32'd6, 32'h0000002A, ML, 1'b1, c0);
    @(negedge clk);
    chk("mul busy E0+1", {31'd0, bus.busy}, 32'd1);
    drain();
    chk("idle after done", {31'd0, bus.busy}, 32'd0);
    chk("result hold", bus.result, 32'h0000002A);

    run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML);
    run(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, ML);
    run(3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, ML);
    run(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);

    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1, c0);
    while (cyc != c0 + 4) @(negedge clk);
    bus.funct3 = 3'b000;
    bus.op1    = 32'd3;
    bus.op2    = 32'd3;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();

    run(3'b111, 32'd100, 32'd7, 32'd2, 33);
    run(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run(3'b111, 32'd5, 32'd0, 32'd5, 1);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    issue(3'b101, 32'd1000, 32'd3, 32'd0, 33, 1'b0, c0);
    while (cyc != c0 + 9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'd0, bus.busy}, 32'd0);
    chk("flush result", bus.result, 32'h80000000);
    repeat (40) @(negedge clk);
    chk("flush result later", bus.result, 32'h80000000);
    run(3'b101, 32'd1000, 32'd3, 32'd333, 33);

    issue(3'b101, 32'd1000, 32'd3, 32'd0, 33, 1'b0, c0);
    while (cyc != c0 + 9) @(negedge clk);
    rst_n      = 1'b0;
    bus.funct3 = 3'b100;
    bus.op1    = 32'd5;
    bus.op2    = 32'd0;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst result", bus.result, 32'd0);
    @(negedge clk);
    chk("rst start dropped", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    run(3'b000, 32'd7, 32'd6, 32'h0000002A, ML);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Operand A comes from the op1 select mux output; operand B comes from the op2 select mux output.
- Starts on a one-cycle start pulse and runs for multiple cycles while busy holds the pipeline.
- Presents a result with a one-cycle done pulse, then holds that result until the next accepted start.

Parameters:
- WORD_LENGTH, 32, operand and result width in bits. Also sets the iteration count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a new operation; accepted only in IDLE.
- flush  input  1  abort the operation in flight (pipeline kill).
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  input  WORD_LENGTH  operand A (rs1/pc/imm from the op1 mux).
- op2  input  WORD_LENGTH  operand B.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  WORD_LENGTH  operation result, held stable until the next accepted start.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, result=0, all internal registers=0. Reset overrides start and flush in the same cycle.
- States:
  - IDLE: on start, latch funct3, op1 and op2, then go to RUN. A special case goes to DONE instead.
  - RUN: iteration counter counts WORD_LENGTH-1 down to 0. When the counter reaches 0, go to DONE.
  - DONE: done=1 and result written for exactly this cycle; next state is IDLE.
- start is ignored outside IDLE. A start in the same cycle as done goes unaccepted; the issuer must re-assert it.
- Latency from start edge E0:
  - Normal ops: RUN for WORD_LENGTH cycles, done high in cycle E0+WORD_LENGTH+1 (33 for default).
  - Special cases: done high in cycle E0+1.
- Operand capture: op1, op2 and funct3 are sampled only at the accepting edge. Later input changes have no effect.
- Multiply: shift-add over |operands|, 2*WORD_LENGTH-bit product.
  - Signedness: MULH treats op1 and op2 as signed. MULHSU treats op1 as signed and op2 as unsigned. MULHU and MUL treat both as unsigned.
  - The final product is negated when the operand signs differ.
  - MUL returns the low WORD_LENGTH bits; MULH, MULHSU and MULHU return the high WORD_LENGTH bits.
- Divide: restoring shift-subtract on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(op1) XOR sign(op2), for signed ops only.
  - Remainder sign = sign(op1).
- Special cases, detected at accept:
  - op2=0: DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (op1 = most negative, op2 = -1): DIV returns op1; REM returns 0.
- flush:
  - In RUN or DONE: next state IDLE, done forced 0 that cycle, result keeps its previous value.
  - In IDLE together with start: start is dropped.
- result changes only in the DONE cycle, or at reset.

Optional Feature:
- Macro: RISCV_MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops use a combinational multiplier on the latched operands. IDLE goes straight to DONE, so done is high at E0+1. Division is unchanged.
- Undefined: all ops are iterative as described above. No hardware multiplier is inferred.

Test Plan:
- MUL 7 x 6 -> done at E0+33 (E0+1 with fast mul), result=0x0000002A, busy high E0+1..E0+33.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; each with done at E0+33.
- DIV 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, done at E0+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, done at E0+1.
- Flush at E0+10 of a DIVU -> IDLE next cycle, done never pulses, result unchanged. A new start then completes normally. A start pulsed at E0+5 during RUN is ignored.
- rst_n=0 for one cycle mid-RUN -> busy=0, done=0, result=0 on the next cycle. A start in that same reset cycle is not accepted.
